// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - sweeps every input code onto a unit and captures its truth table
// Optional stability check of each held code: `define STABILITY_CHECK_EN
module truth_table_sequencer #(
    parameter int N_IN  = 3,
    parameter int DWELL = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic [N_IN-1:0]      a_out,
    input  logic                 m_in,
    output logic                 busy,
    output logic                 done,
    output logic                 table_valid,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 unstable
);

    localparam int              DEPTH     = 2**N_IN;
    localparam logic [15:0]     CNT_LAST  = 16'(DWELL - 1);
    localparam logic [N_IN-1:0] CODE_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [15:0]        cnt, cnt_n;
    logic [N_IN-1:0]    a_n;
    logic               busy_n;
    logic               done_n;
    logic               valid_n;
    logic [DEPTH-1:0]   table_n;

`ifdef STABILITY_CHECK_EN
    // With a single-cycle hold the first and last samples coincide, so nothing can be flagged.
    localparam bit CHECK_OK = (DWELL >= 2);

    logic first_q, first_n;
    logic unst_q, unst_n;

    assign unstable = unst_q;
`else
    assign unstable = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            a_out       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            table_valid <= 1'b0;
            table_out   <= '0;
`ifdef STABILITY_CHECK_EN
            first_q     <= 1'b0;
            unst_q      <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            a_out       <= a_n;
            busy        <= busy_n;
            done        <= done_n;
            table_valid <= valid_n;
            table_out   <= table_n;
`ifdef STABILITY_CHECK_EN
            first_q     <= first_n;
            unst_q      <= unst_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = a_out;
        busy_n  = busy;
        done_n  = 1'b0;
        valid_n = table_valid;
        table_n = table_out;
`ifdef STABILITY_CHECK_EN
        first_n = first_q;
        unst_n  = unst_q;
`endif

        case (state)
            S_IDLE: begin
                // Old table stays visible until overwritten bit by bit.
                if (start) begin
                    state_n = S_RUN;
                    busy_n  = 1'b1;
                    a_n     = '0;
                    cnt_n   = '0;
                    valid_n = 1'b0;
`ifdef STABILITY_CHECK_EN
                    unst_n  = 1'b0;
`endif
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                    a_n     = '0;
                    cnt_n   = '0;
                end else begin
`ifdef STABILITY_CHECK_EN
                    if (cnt == 16'd0) begin
                        first_n = m_in;
                    end
                    if (CHECK_OK && (cnt == CNT_LAST) && (m_in != first_q)) begin
                        unst_n = 1'b1;
                    end
`endif
                    if (cnt == CNT_LAST) begin
                        table_n[a_out] = m_in;
                        cnt_n          = '0;
                        if (a_out != CODE_LAST) begin
                            a_n = a_out + 1'b1;
                        end else begin
                            state_n = S_FIN;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            valid_n = 1'b1;
                            a_n     = '0;
                        end
                    end else begin
                        cnt_n = cnt + 16'd1;
                    end
                end
            end

            S_FIN: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - scoreboard bench for truth_table_sequencer (N_IN=3, DWELL=4)
module tb_truth_table_sequencer;

    localparam int N_IN  = 3;
    localparam int DWELL = 4;
    localparam int SWEEP = (2**N_IN) * DWELL;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] a_out;
    logic       m_in;
    logic       busy, done, table_valid, unstable;
    logic [7:0] table_out;

    int  func = 0;
    bit  glitch_en = 1'b0;
    bit  flip = 1'b0;
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    logic prev_done = 1'b0;

    typedef struct {
        logic [7:0] tbl;
        logic       unst;
        int         done_cyc;
    } exp_t;

    exp_t sb[$];

    truth_table_sequencer #(.N_IN(N_IN), .DWELL(DWELL)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a_out(a_out), .m_in(m_in), .busy(busy), .done(done),
        .table_valid(table_valid), .table_out(table_out), .unstable(unstable)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic unit_fn(input int f, input logic [2:0] a);
        if (f == 0) return (a[0] & a[1]) | (a[0] & a[2]) | (a[1] & a[2]);
        return a[0] ^ a[1] ^ a[2];
    endfunction

    assign m_in = unit_fn(func, a_out) ^ flip;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected sweep.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_done) chk("done_width", {31'd0, done}, 32'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("table_out", {24'd0, table_out}, {24'd0, e.tbl});
                    chk("table_valid", {31'd0, table_valid}, 32'd1);
                    chk("busy_at_done", {31'd0, busy}, 32'd0);
                    chk("unstable", {31'd0, unstable}, {31'd0, e.unst});
                    chk("done_cycle", cyc, e.done_cyc);
                end
            end
        end
        prev_done <= done;
    end

    // Flips the unit output from cnt=2 of code 6 until the code changes.
    initial forever begin
        @(negedge clk);
        if (glitch_en && busy && a_out == 3'd6) begin
            @(posedge clk);
            @(posedge clk);
            #1 flip = 1'b1;
            while (a_out == 3'd6) @(negedge clk);
            flip = 1'b0;
        end
    end

    function automatic exp_t make_exp(input int f, input bit gl, input int start_cyc);
        exp_t e;
        for (int k = 0; k < 8; k++) e.tbl[k] = unit_fn(f, 3'(k));
        if (gl) e.tbl[6] = ~e.tbl[6];
`ifdef STABILITY_CHECK_EN
        e.unst = gl;
`else
        e.unst = 1'b0;
`endif
        e.done_cyc = start_cyc + SWEEP;
        return e;
    endfunction

    task automatic launch(input int f, input bit gl);
        @(negedge clk);
        func = f;
        glitch_en = gl;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        sb.push_back(make_exp(f, gl, cyc));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("sweep_timeout", 32'd1, 32'd0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
        glitch_en = 1'b0;
    endtask

    task automatic wait_code(input logic [2:0] code);
        int n = 0;
        while (a_out != code && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (a_out != code) chk("code_timeout", {29'd0, a_out}, {29'd0, code});
    endtask

    initial begin
        int c;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_out", {29'd0, a_out}, 32'd0);
        chk("rst_flags", {28'd0, busy, done, table_valid, unstable}, 32'd0);
        chk("rst_table", {24'd0, table_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Majority: check the code stepping across the whole sweep.
        launch(0, 1'b0);
        for (int k = 0; k < SWEEP; k++) begin
            chk("a_out_step", {29'd0, a_out}, k / DWELL);
            chk("busy_run", {31'd0, busy}, 32'd1);
            @(posedge clk);
            #1;
        end
        wait_idle();
        chk("a_out_wrap", {29'd0, a_out}, 32'd0);

        // XOR3, with a start pulse during the run that must be ignored.
        launch(1, 1'b0);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Abort at code 5, cnt=2.
        launch(0, 1'b0);
        wait_code(3'd5);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        sb.delete();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_a_out", {29'd0, a_out}, 32'd0);
        chk("abort_valid", {31'd0, table_valid}, 32'd0);
        repeat (40) @(negedge clk);
        chk("abort_valid_late", {31'd0, table_valid}, 32'd0);
        launch(0, 1'b0);
        wait_idle();

        // Reset mid-sweep at code 3.
        launch(1, 1'b0);
        wait_code(3'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        chk("midrst_a_out", {29'd0, a_out}, 32'd0);
        chk("midrst_flags", {28'd0, busy, done, table_valid, unstable}, 32'd0);
        chk("midrst_table", {24'd0, table_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // start held high: relaunch the cycle after DONE.
        @(negedge clk);
        func = 1;
        start = 1'b1;
        @(posedge clk);
        #1;
        c = cyc;
        sb.push_back(make_exp(1, 1'b0, c));
        sb.push_back(make_exp(1, 1'b0, c + SWEEP + 2));
        while (cyc < c + SWEEP + 1) begin
            @(posedge clk);
            #1;
        end
        chk("held_idle_gap", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("held_relaunch", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_idle();

        // Glitch on code 6: table bit flips; unstable only with the check built in.
        launch(0, 1'b1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
